wb_stage: RTL and testbench

//  Writeback stage of the RV32I core; drives the register file write port directly.

---
 rtl/core_pkg.sv | 21 ++
 rtl/wb_stage_if.sv | 24 ++
 rtl/wb_stage_load_align.sv | 48 ++++
 rtl/wb_stage.sv | 122 ++++++++++++
 tb/tb_wb_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared writeback-stage constants and FSM state encoding
package core_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DRAIN   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM-to-writeback instruction handshake bundle
interface wb_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            m_valid;
  logic            m_ready;
  logic            m_reg_we;
  logic [RA_W-1:0] m_rd_addr;
  logic [1:0]      m_wb_sel;
  logic [2:0]      m_funct3;
  logic [XLEN-1:0] m_alu_result;
  logic [XLEN-1:0] m_pc_plus4;

  modport master (
    output m_valid, m_reg_we, m_rd_addr, m_wb_sel, m_funct3, m_alu_result, m_pc_plus4,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_reg_we, m_rd_addr, m_wb_sel, m_funct3, m_alu_result, m_pc_plus4,
    output m_ready
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - byte/half/word select and extension of a word-aligned load
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Unknown funct3 codes fall back to word semantics.
  always_comb begin
    o_data     = '0;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH, F3_LHU: begin
        o_misalign = i_addr[0];
        if (!i_addr[0]) begin
          o_data = (i_funct3 == F3_LH) ? {{(XLEN-16){w_half[15]}}, w_half}
                                       : {{(XLEN-16){1'b0}}, w_half};
        end
      end
      default: begin
        o_misalign = (i_addr != 2'd0);
        if (i_addr == 2'd0) o_data = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I writeback stage: single-entry hold, load wait, rf write, instret
// Optional macro WB_BYPASS_EN adds forwarding outputs fwd_valid/fwd_addr/fwd_data/fwd_pending.
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  wb_stage_if.slave       mif,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
  output logic            ld_misalign,
  output logic [31:0]     instret
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd_valid,
  output logic [RA_W-1:0] fwd_addr,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_pending
`endif
);

  wb_state_t       r_state;
  wb_state_t       w_next;
  logic            r_reg_we;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_misalign;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [31:0]     r_instret;

  logic            w_ready;
  logic            w_accept;
  logic            w_is_load;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_mis;

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata    (dmem_rdata),
    .i_addr     (r_addr_lo),
    .i_funct3   (r_funct3),
    .o_data     (w_ld_data),
    .o_misalign (w_ld_mis)
  );

  assign w_is_load   = (mif.m_wb_sel == WB_SEL_LOAD);
  assign w_accept    = mif.m_valid && w_ready;
  assign mif.m_ready = w_ready;

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    rf_we       = 1'b0;
    ld_misalign = 1'b0;
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        w_ready = !flush;
        if (r_state == ST_COMMIT) begin
          rf_we       = r_reg_we && (r_rd != '0);
          ld_misalign = r_misalign;
        end
        if (w_accept) w_next = w_is_load ? ST_WAIT_LD : ST_COMMIT;
        else          w_next = ST_IDLE;
      end
      ST_WAIT_LD: begin
        // A response arriving with the flush is the one being drained.
        if (flush)            w_next = dmem_rvalid ? ST_IDLE : ST_DRAIN;
        else if (dmem_rvalid) w_next = ST_COMMIT;
      end
      default: begin
        if (dmem_rvalid) w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_reg_we   <= 1'b0;
      r_rd       <= '0;
      r_data     <= '0;
      r_misalign <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr_lo  <= 2'd0;
      r_instret  <= 32'd0;
    end else begin
      r_state <= w_next;
      // Counting on entry makes instret include the instruction now in COMMIT.
      if (w_next == ST_COMMIT) r_instret <= r_instret + 32'd1;
      if (w_accept) begin
        r_reg_we   <= mif.m_reg_we;
        r_rd       <= mif.m_rd_addr;
        r_funct3   <= mif.m_funct3;
        r_addr_lo  <= mif.m_alu_result[1:0];
        r_misalign <= 1'b0;
        r_data     <= (mif.m_wb_sel == WB_SEL_PC4) ? mif.m_pc_plus4 : mif.m_alu_result;
      end else if (r_state == ST_WAIT_LD && dmem_rvalid && !flush) begin
        r_data     <= w_ld_data;
        r_misalign <= w_ld_mis;
      end
    end
  end

  assign rf_rd_addr = r_rd;
  assign rf_rd_data = r_data;
  assign instret    = r_instret;

`ifdef WB_BYPASS_EN
  assign fwd_valid   = rf_we;
  assign fwd_addr    = r_rd;
  assign fwd_data    = r_data;
  assign fwd_pending = (r_state == ST_WAIT_LD) && r_reg_we;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - randomized writeback-stage bench against a behavioural model
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        ld_misalign;
  logic [31:0] instret;
`ifdef WB_BYPASS_EN
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        fwd_pending;
`endif

  wb_stage_if #(.XLEN(32), .RA_W(5)) mif ();

  wb_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .mif         (mif),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .rf_we       (rf_we),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .ld_misalign (ld_misalign),
    .instret     (instret)
`ifdef WB_BYPASS_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_pending (fwd_pending)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: what the stage holds, described by what it is doing rather than how.
  bit          h_commit, h_wait, h_drain;
  bit          h_we, h_mis;
  logic [4:0]  h_rd;
  logic [31:0] h_data;
  logic [2:0]  h_f3;
  logic [1:0]  h_addr;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] load_result(input logic [31:0] w, input logic [1:0] a,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * a);
    b  = sh[7:0];
    sh = w >> (16 * a[1]);
    h  = sh[15:0];
    case (f3)
      3'b000:  return {1'b0, {{24{b[7]}}, b}};
      3'b100:  return {1'b0, 24'd0, b};
      3'b001:  return a[0] ? {1'b1, 32'd0} : {1'b0, {{16{h[15]}}, h}};
      3'b101:  return a[0] ? {1'b1, 32'd0} : {1'b0, 16'd0, h};
      default: return (a != 2'd0) ? {1'b1, 32'd0} : {1'b0, w};
    endcase
  endfunction

  task automatic mdl_reset();
    h_commit = 0; h_wait = 0; h_drain = 0; h_we = 0; h_mis = 0;
    h_rd = '0; h_data = '0; h_f3 = '0; h_addr = '0; m_count = '0;
  endtask

  task automatic compare();
    bit exp_ready;
    exp_ready = !(h_wait || h_drain) && !flush;
    chk("m_ready", {31'd0, mif.m_ready}, {31'd0, exp_ready});
    chk("rf_we", {31'd0, rf_we}, {31'd0, h_commit && h_we && (h_rd != 0)});
    chk("ld_misalign", {31'd0, ld_misalign}, {31'd0, h_commit && h_mis});
    chk("instret", instret, m_count);
    if (h_commit) begin
      chk("rf_rd_addr", {27'd0, rf_rd_addr}, {27'd0, h_rd});
      chk("rf_rd_data", rf_rd_data, h_data);
    end
`ifdef WB_BYPASS_EN
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, h_commit && h_we && (h_rd != 0)});
    chk("fwd_pending", {31'd0, fwd_pending}, {31'd0, h_wait && h_we});
    if (h_commit) chk("fwd_data", fwd_data, h_data);
`endif
  endtask

  task automatic mdl_step();
    logic [32:0] r;
    bit ready;
    ready = !(h_wait || h_drain) && !flush;
    if (h_wait) begin
      if (flush) begin
        h_wait  = 0;
        h_drain = !dmem_rvalid;
      end else if (dmem_rvalid) begin
        r = load_result(dmem_rdata, h_addr, h_f3);
        h_mis = r[32]; h_data = r[31:0];
        h_wait = 0; h_commit = 1; m_count++;
      end
    end else if (h_drain) begin
      if (dmem_rvalid) h_drain = 0;
    end else begin
      h_commit = 0;
      if (mif.m_valid && ready) begin
        h_we = mif.m_reg_we; h_rd = mif.m_rd_addr; h_f3 = mif.m_funct3;
        h_addr = mif.m_alu_result[1:0]; h_mis = 0;
        if (mif.m_wb_sel == 2'd1) h_wait = 1;
        else begin
          h_data = (mif.m_wb_sel == 2'd2) ? mif.m_pc_plus4 : mif.m_alu_result;
          h_commit = 1; m_count++;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input bit we, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [2:0] f3, input logic [31:0] alu, input bit fl,
                     input bit rv, input logic [31:0] rdat);
    @(negedge clk);
    mif.m_valid = v; mif.m_reg_we = we; mif.m_rd_addr = rd; mif.m_wb_sel = sel;
    mif.m_funct3 = f3; mif.m_alu_result = alu; mif.m_pc_plus4 = alu ^ 32'h5A5A_0004;
    flush = fl; dmem_rvalid = rv; dmem_rdata = rdat;
    #1;
    compare();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rv, input logic [31:0] rdat);
    cyc(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 0, rv, rdat);
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    mif.m_valid = 0; mif.m_reg_we = 0; mif.m_rd_addr = '0; mif.m_wb_sel = '0;
    mif.m_funct3 = '0; mif.m_alu_result = '0; mif.m_pc_plus4 = '0;
    mdl_reset();
    #23;
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("reset rf_rd_data", rf_rd_data, 32'd0);
    chk("reset ld_misalign", {31'd0, ld_misalign}, 32'd0);
    chk("reset instret", instret, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("reset m_ready", {31'd0, mif.m_ready}, 32'd1);

    cyc(1, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 0, 0, 0);
    chk("alu rf_we", {31'd0, rf_we}, 32'd1);
    chk("alu rf_rd_addr", {27'd0, rf_rd_addr}, 32'd5);
    chk("alu rf_rd_data", rf_rd_data, 32'h1234);
    chk("alu instret", instret, 32'd1);
    idle(0, 0);

    for (int i = 0; i < 3; i++) cyc(1, 1, 5'(i + 1), 2'd0, 3'd0, 32'(i * 3 + 7), 0, 0, 0);
    idle(0, 0);
    chk("b2b instret", instret, 32'd4);

    cyc(1, 1, 5'd3, 2'd1, 3'b000, 32'h0000_0103, 0, 0, 0);
    chk("lb wait m_ready", {31'd0, mif.m_ready}, 32'd0);
    for (int i = 0; i < 3; i++) idle(0, 0);
    idle(1, 32'h80FF_00AA);
    chk("lb data", rf_rd_data, 32'hFFFF_FF80);
    chk("lb instret", instret, 32'd5);

    cyc(1, 1, 5'd4, 2'd1, 3'b101, 32'h0000_0202, 0, 0, 0);
    idle(0, 0);
    idle(1, 32'hBEEF_1234);
    chk("lhu data", rf_rd_data, 32'h0000_BEEF);

    cyc(1, 1, 5'd6, 2'd1, 3'b001, 32'h0000_0201, 0, 0, 0);
    idle(1, 32'hBEEF_1234);
    chk("lh mis data", rf_rd_data, 32'd0);
    chk("lh mis flag", {31'd0, ld_misalign}, 32'd1);
    chk("lh mis rf_we", {31'd0, rf_we}, 32'd1);

    cyc(1, 1, 5'd0, 2'd0, 3'd0, 32'hDEAD, 0, 0, 0);
    chk("rd0 rf_we", {31'd0, rf_we}, 32'd0);
    chk("rd0 instret", instret, 32'd8);

    cyc(1, 1, 5'd7, 2'd1, 3'b010, 32'h0000_0400, 0, 0, 0);
    cyc(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 1, 0, 0);
    idle(0, 0);
    idle(1, 32'h1111_2222);
    chk("drain rf_we", {31'd0, rf_we}, 32'd0);
    chk("drain m_ready", {31'd0, mif.m_ready}, 32'd1);
    chk("drain instret", instret, 32'd8);

    cyc(1, 1, 5'd9, 2'd1, 3'b010, 32'h0000_0800, 0, 0, 0);
    mif.m_valid = 0; flush = 0; dmem_rvalid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async rf_we", {31'd0, rf_we}, 32'd0);
    chk("async rf_rd_addr", {27'd0, rf_rd_addr}, 32'd0);
    chk("async rf_rd_data", rf_rd_data, 32'd0);
    chk("async ld_misalign", {31'd0, ld_misalign}, 32'd0);
    chk("async instret", instret, 32'd0);
    chk("async m_ready", {31'd0, mif.m_ready}, 32'd1);
    mdl_reset();
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      bit rv;
      rv = (h_wait || h_drain) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      cyc(($urandom_range(3) != 0), 1'($urandom), 5'($urandom), 2'($urandom),
          f3s[$urandom_range(4)], $urandom, ($urandom_range(15) == 0), rv, $urandom);
    end
    idle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
